// File: rtl/regfile_xfer.sv
// Bulk transfer controller: dumps every register as a valid/ready stream, or
// loads every register from one, using the register file's read and write ports.
module regfile_xfer #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          mode,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_idx,
   output logic          out_valid,
   input  logic          out_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [AW-1:0] rf_readReg,
   input  logic [DW-1:0] rf_data,
   output logic [AW-1:0] rf_writeReg,
   output logic [DW-1:0] rf_writeData,
   output logic          rf_RegWrite
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DUMP,
      S_LOAD,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          issued_q, issued_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [AW-1:0] out_idx_q, out_idx_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         issued_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         issued_q    <= issued_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      issued_d    = issued_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      in_ready    = 1'b0;
      done        = 1'b0;

      if (abort) begin
         state_d     = S_IDLE;
         idx_d       = '0;
         issued_d    = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d  = mode ? S_LOAD : S_DUMP;
                  idx_d    = '0;
                  issued_d = 1'b0;
               end
            end
            S_DUMP: begin
               // Output register acts as a one-deep skid: refill when empty or draining.
               if ((!out_valid_q || out_ready) && !issued_q) begin
                  out_data_d  = rf_data;
                  out_idx_d   = idx_q;
                  out_valid_d = 1'b1;
                  if (idx_q == LAST_IDX) begin
                     issued_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else if (out_valid_q && out_ready && issued_q) begin
                  out_valid_d = 1'b0;
                  state_d     = S_DONE;
               end
            end
            S_LOAD: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               done     = 1'b1;
               state_d  = S_IDLE;
               idx_d    = '0;
               issued_d = 1'b0;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Reset must silence the write port immediately, even mid-transfer.
      if (reset) begin
         in_ready = 1'b0;
         done     = 1'b0;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_idx      = out_idx_q;
   assign rf_readReg   = idx_q;
   assign rf_writeReg  = idx_q;
   assign rf_writeData = in_data;
   assign rf_RegWrite  = in_valid & in_ready;

endmodule

// File: tb/tb_regfile_xfer.sv
// Bench for regfile_xfer: a behavioural register file plus an expected-contents
// array; dump streams and load writes are compared against that array.
module tb_regfile_xfer;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic          clk = 1'b0;
   logic          reset, start, mode, abort, out_ready, in_valid;
   logic [DW-1:0] in_data;
   logic          busy, done, out_valid, in_ready, rf_RegWrite;
   logic [DW-1:0] out_data, rf_data, rf_writeData;
   logic [AW-1:0] out_idx, rf_readReg, rf_writeReg;

   logic [DW-1:0] rf_mem   [NREG];
   logic [DW-1:0] exp_regs [NREG];
   logic [DW-1:0] ldata    [NREG];
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] got_idx[$];
   logic [DW-1:0] got_data[$];
   int d_done_cnt, d_done_c, d_first_c, d_stall_bad, d_timeout, d_end_c;
   int l_done_cnt, l_done_c, l_last_acc_c, l_bad, l_timeout, l_end_c, l_acc, l_abort_c;
   logic l_ready0;

   always #5 clk = ~clk;

   regfile_xfer #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
      .busy(busy), .done(done), .out_data(out_data), .out_idx(out_idx),
      .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .rf_readReg(rf_readReg),
      .rf_data(rf_data), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
      .rf_RegWrite(rf_RegWrite)
   );

   // Register file: combinational read, write on the rising edge.
   assign rf_data = rf_mem[rf_readReg];
   always @(posedge clk) begin
      if (pre_we) rf_mem[pre_addr] <= pre_data;
      else if (rf_RegWrite) rf_mem[rf_writeReg] <= rf_writeData;
   end

   task automatic preload(input bit rnd);
      for (int i = 0; i < NREG; i++) begin
         @(negedge clk);
         pre_we = 1'b1;
         pre_addr = AW'(i);
         pre_data = rnd ? DW'($urandom) : DW'(i * 3);
         exp_regs[i] = pre_data;
      end
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic dump_run(input int rmode, input bit poke_start);
      logic pv, pr;
      logic [DW-1:0] pd;
      logic [AW-1:0] pix;
      int c;
      bit fin;
      got_idx.delete();
      got_data.delete();
      d_done_cnt = 0; d_done_c = -1; d_first_c = -1; d_stall_bad = 0; d_timeout = 1;
      pv = 1'b0; pr = 1'b0; pd = '0; pix = '0;
      @(negedge clk); start = 1'b1; mode = 1'b0;
      @(negedge clk); start = 1'b0;
      c = 0; fin = 0;
      while (!fin && c < 400) begin
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         start = poke_start && (c < 20);
         mode = 1'b1;
         #1;
         if (done) begin d_done_cnt++; d_done_c = c; end
         if (!busy) begin
            fin = 1; d_timeout = 0;
         end else begin
            if (out_valid && d_first_c < 0) d_first_c = c;
            if (pv && !pr && (!out_valid || out_data !== pd || out_idx !== pix)) d_stall_bad++;
            if (out_valid && out_ready) begin
               got_idx.push_back(out_idx);
               got_data.push_back(out_data);
            end
            pv = out_valid; pr = out_ready; pd = out_data; pix = out_idx;
            @(negedge clk);
            c++;
         end
      end
      d_end_c = c;
      start = 1'b0; mode = 1'b0; out_ready = 1'b0;
      $display("dump: beats=%0d done_cycle=%0d end_cycle=%0d", got_idx.size(), d_done_c, d_end_c);
   endtask

   task automatic load_run(input int abort_after, input bit rnd);
      int c, acc;
      bit fin, aborted;
      for (int i = 0; i < NREG; i++) ldata[i] = rnd ? DW'($urandom) : DW'(100 + i);
      l_done_cnt = 0; l_done_c = -1; l_last_acc_c = -1; l_bad = 0; l_timeout = 1; l_abort_c = -1;
      @(negedge clk); start = 1'b1; mode = 1'b1;
      @(negedge clk); start = 1'b0;
      c = 0; acc = 0; fin = 0; aborted = 0;
      while (!fin && c < 400) begin
         abort = (abort_after >= 0) && (acc == abort_after) && !aborted;
         in_valid = abort || ((c % 3) != 2);
         in_data = (acc < NREG) ? ldata[acc] : DW'($urandom);
         #1;
         if (c == 0) l_ready0 = in_ready;
         if (done) begin l_done_cnt++; l_done_c = c; end
         if (!busy) begin
            fin = 1; l_timeout = 0;
         end else begin
            if (abort) begin
               aborted = 1; l_abort_c = c;
               if (in_ready || rf_RegWrite) l_bad++;
            end else begin
               if (in_ready !== (acc < NREG)) l_bad++;
               if (rf_RegWrite !== (in_valid && acc < NREG)) l_bad++;
               if (rf_RegWrite && acc < NREG) begin
                  if (rf_writeReg !== AW'(acc) || rf_writeData !== ldata[acc]) l_bad++;
                  exp_regs[acc] = ldata[acc];
                  l_last_acc_c = c;
                  acc++;
               end
            end
            @(negedge clk);
            c++;
         end
      end
      l_acc = acc; l_end_c = c;
      in_valid = 1'b0; abort = 1'b0;
      $display("load: accepted=%0d done_cycle=%0d end_cycle=%0d", l_acc, l_done_c, l_end_c);
   endtask

   task automatic check_dump_contents(input string tag);
      checks++;
      if (d_timeout != 0 || got_idx.size() != NREG) begin
         errors++;
         $display("FAIL %s_count: got %0d beats (timeout=%0d) expected %0d", tag, got_idx.size(), d_timeout, NREG);
      end
      for (int i = 0; i < got_idx.size() && i < NREG; i++) begin
         checks++;
         if (got_idx[i] !== AW'(i) || got_data[i] !== exp_regs[i]) begin
            errors++;
            $display("FAIL %s_beat%0d: got idx=%0d data=%0h expected idx=%0d data=%0h",
                     tag, i, got_idx[i], got_data[i], i, exp_regs[i]);
         end
      end
      checks++;
      if (d_done_cnt != 1) begin
         errors++;
         $display("FAIL %s_done_pulses: got %0d expected 1", tag, d_done_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; mode = 1'b0; abort = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; in_data = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({busy, done, out_valid, in_ready, rf_RegWrite} !== 5'b0 ||
          out_data !== '0 || out_idx !== '0 || rf_readReg !== '0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b ov=%b ir=%b we=%b od=%0h oi=%0d rr=%0d expected all zero",
                  busy, done, out_valid, in_ready, rf_RegWrite, out_data, out_idx, rf_readReg);
      end
      reset = 1'b0; start = 1'b0; in_valid = 1'b0;
      $display("reset: done");
   endtask

   task automatic test_dump();
      preload(0);
      dump_run(0, 0);
      check_dump_contents("dump");
      checks++;
      if (d_first_c != 1) begin
         errors++;
         $display("FAIL dump_first_valid: got cycle %0d expected 1", d_first_c);
      end
      checks++;
      if (d_done_c != NREG + 1) begin
         errors++;
         $display("FAIL dump_done_cycle: got %0d expected %0d", d_done_c, NREG + 1);
      end
      checks++;
      if (d_end_c != NREG + 2) begin
         errors++;
         $display("FAIL dump_busy_fall: got %0d expected %0d", d_end_c, NREG + 2);
      end
   endtask

   task automatic test_backpressure();
      preload(1);
      dump_run(1, 1);
      check_dump_contents("bp");
      checks++;
      if (d_stall_bad != 0) begin
         errors++;
         $display("FAIL bp_stall_stable: got %0d changes expected 0", d_stall_bad);
      end
      dump_run(2, 0);
      check_dump_contents("bp_rand");
      checks++;
      if (d_stall_bad != 0) begin
         errors++;
         $display("FAIL bp_rand_stall_stable: got %0d changes expected 0", d_stall_bad);
      end
   endtask

   task automatic test_load();
      load_run(-1, 0);
      checks++;
      if (l_timeout != 0 || l_acc != NREG || l_bad != 0 || l_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL load_beats: got acc=%0d bad=%0d timeout=%0d ready0=%b expected acc=%0d bad=0 timeout=0 ready0=1",
                  l_acc, l_bad, l_timeout, l_ready0, NREG);
      end
      checks++;
      if (l_done_cnt != 1 || l_done_c != l_last_acc_c + 1 || l_end_c != l_done_c + 1) begin
         errors++;
         $display("FAIL load_done: got pulses=%0d at %0d end=%0d expected 1 at %0d end=%0d",
                  l_done_cnt, l_done_c, l_end_c, l_last_acc_c + 1, l_last_acc_c + 2);
      end
      dump_run(0, 0);
      check_dump_contents("load_readback");
   endtask

   task automatic test_abort();
      load_run(10, 1);
      checks++;
      if (l_timeout != 0 || l_acc != 10 || l_bad != 0) begin
         errors++;
         $display("FAIL abort_beats: got acc=%0d bad=%0d timeout=%0d expected acc=10 bad=0 timeout=0",
                  l_acc, l_bad, l_timeout);
      end
      checks++;
      if (l_done_cnt != 0 || l_end_c != l_abort_c + 1) begin
         errors++;
         $display("FAIL abort_idle: got pulses=%0d idle_at=%0d expected pulses=0 idle_at=%0d",
                  l_done_cnt, l_end_c, l_abort_c + 1);
      end
      dump_run(0, 0);
      check_dump_contents("abort_readback");
   endtask

   task automatic test_reset_mid();
      int c;
      @(negedge clk); start = 1'b1; mode = 1'b0;
      @(negedge clk); start = 1'b0; out_ready = 1'b1;
      c = 0;
      #1;
      while (!(out_valid && out_idx == AW'(5)) && c < 20) begin
         @(negedge clk); #1; c++;
      end
      checks++;
      if (c >= 20) begin
         errors++;
         $display("FAIL reset_mid_reach_idx5: got timeout after %0d cycles expected idx 5 valid", c);
      end
      out_ready = 1'b0; reset = 1'b1; start = 1'b1; in_valid = 1'b1;
      #1;
      checks++;
      if (rf_RegWrite !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_comb: got we=%b ir=%b done=%b expected 0 0 0", rf_RegWrite, in_ready, done);
      end
      @(negedge clk); reset = 1'b0; start = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_mid_state: got ov=%b busy=%b oi=%0d od=%0h expected 0 0 0 0",
                  out_valid, busy, out_idx, out_data);
      end
      // Reset during a load: write data equals current contents, so nothing changes.
      @(negedge clk); start = 1'b1; mode = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = exp_regs[i];
         @(negedge clk);
      end
      reset = 1'b1; in_valid = 1'b1; in_data = ~exp_regs[3];
      #1;
      checks++;
      if (rf_RegWrite !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_load: got we=%b ir=%b expected 0 0", rf_RegWrite, in_ready);
      end
      @(negedge clk); reset = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_load_busy: got %b expected 0", busy);
      end
      dump_run(0, 0);
      check_dump_contents("reset_readback");
   endtask

   initial begin
      test_reset();
      test_dump();
      test_backpressure();
      test_load();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_xfer.md
# regfile_xfer

Bulk-transfer controller on the initiator side of the register file's read/write port. On command it either dumps all registers out as a valid/ready stream or loads all registers from an incoming valid/ready stream. It sits between the register file and a debug or context-save path. The register file keeps its existing contract: combinational read, write on the rising clock edge when RegWrite is high.

## Interface
- NREG, 32: number of registers transferred; indices 0..NREG-1.
- AW, 5: register index width; NREG <= 2^AW.
- DW, 32: data width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = dump, 1 = load; sampled with start.
- abort  in  1  return to IDLE from any state.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on completion.
- out_data  out  DW  dumped register value.
- out_idx  out  AW  index of out_data.
- out_valid  out  1  dump stream valid.
- out_ready  in  1  dump stream ready.
- in_data  in  DW  load stream data.
- in_valid  in  1  load stream valid.
- in_ready  out  1  load stream ready.
- rf_readReg  out  AW  register-file read address; equals idx.
- rf_data  in  DW  register-file read data; combinational from rf_readReg.
- rf_writeReg  out  AW  register-file write address; equals idx.
- rf_writeData  out  DW  equals in_data.
- rf_RegWrite  out  1  register-file write enable.

## Operation
- States: IDLE, DUMP, LOAD, DONE. idx counter is AW bits wide. A flag `issued` means every index has been captured.
- Reset values: state=IDLE, idx=0, issued=0, out_valid=0, out_data=0, out_idx=0, done=0, busy=0.
- Reset behaviour: while reset is high, in_ready=0 and rf_RegWrite=0 combinationally, including mid-transfer.
- IDLE:
  - start=1, mode=0: go to DUMP, idx=0.
  - start=1, mode=1: go to LOAD, idx=0.
  - start while busy is ignored.
- DUMP, capture condition: out_valid=0, or out_valid=1 and out_ready=1, with issued=0.
- DUMP, on capture: out_data<=rf_data, out_idx<=idx, out_valid<=1. If idx=NREG-1, set issued; otherwise idx++.
- DUMP, handshake with issued=1: out_valid<=0 and go to DONE.
- DUMP, out_ready low: out_data, out_idx and out_valid hold stable.
- LOAD:
  - in_ready=1.
  - rf_RegWrite = in_valid & in_ready, combinational.
  - Each accepted beat writes in_data into register idx.
  - Accepted beat with idx=NREG-1: go to DONE. Otherwise idx++.
  - Register 0 is written like any other register; any hardwiring is the register file's concern.
- DONE: done=1 for exactly one cycle, then go to IDLE with idx=0 and issued=0.
- abort, in any state: next state IDLE, out_valid<=0, idx<=0, issued<=0, no done pulse. In the abort cycle in_ready=0 and rf_RegWrite=0.
- Simultaneous reset and abort: reset behaviour applies (identical result).
- idx never wraps: the terminal index ends the transfer.

## Timing
- start sampled at edge k:
  - DUMP: first out_valid at cycle k+2 (state entered at k+1, capture at edge k+1→k+2).
  - LOAD: in_ready high from cycle k+1.
- Dump throughput: one word per cycle when out_ready is held high. NREG words finish in NREG+1 cycles after DUMP entry. done pulses in the cycle after the final handshake.
- Load throughput: one word per cycle. A beat accepted in cycle c is visible on the register file read port from cycle c+1. done pulses in the cycle after the last accepted beat.
- busy rises in the cycle after start is sampled and falls in the cycle after done.

## Test plan
- Dump with out_ready=1, registers preloaded with reg[i]=i*3 (reg[0]=0, reg[31]=93): exactly 32 beats with out_idx 0..31 and matching data, then done is a single-cycle pulse, then busy=0.
- Dump with back-pressure, out_ready toggling 1,0,0,1 repeating: no beat dropped or duplicated. out_data and out_idx stay stable while stalled.
- Load 32 beats, in_data=100+i, with in_valid gaps every third cycle: rf_RegWrite asserts only on accepted beats. A following dump returns 100..131.
- Abort after 10 load beats: registers 0..9 updated, 10..31 unchanged, no done pulse, busy=0 next cycle, a new start accepted.
- Synchronous reset asserted mid-dump, with out_valid=1 at idx 5: rf_RegWrite=0, out_valid=0, busy=0 after the edge. start asserted while busy=1 has no effect.
